udp_hdr_insert: RTL and testbench
=================================

Name: udp_hdr_insert

Overview:
- Downstream neighbour of the total-length stage (totlen).
- Consumes its length stream (payload byte count) and its buffered payload byte stream.
- Emits a complete UDP datagram byte stream: 8-byte UDP header (src port, dst port, UDP length = payload+8, checksum = 0), then the payload unchanged.
- Output feeds the IP header stage.

Parameters:
- SRC_PORT, 16'h1234, UDP source port placed in header bytes 0-1.
- DST_PORT, 16'h5678, UDP destination port placed in header bytes 2-3.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- length_tvalid  in  1  payload length word valid.
- length_tready  out  1  length word accepted.
- length_tdata  in  16  payload byte count.
- s_tvalid  in  1  payload byte valid.
- s_tready  out  1  payload byte accepted.
- s_tdata  in  8  payload byte.
- s_tlast  in  1  last payload byte of packet.
- m_tvalid  out  1  datagram byte valid.
- m_tready  in  1  downstream ready.
- m_tdata  out  8  datagram byte.
- m_tlast  out  1  last datagram byte.
- len_err  out  1  one-cycle pulse: counted payload bytes != captured length.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, byte counter=0, captured length=0. Outputs: length_tready=0 during reset cycle then 1 in IDLE; s_tready=0; m_tvalid=0; m_tlast=0; len_err=0.
- Reset asserted mid-packet: returns to IDLE next cycle. Partially sent datagram is abandoned (no m_tlast). Upstream remnants are not drained.
- AXI-stream rules on every interface:
  - Transfer occurs when valid&&ready.
  - m_tvalid and m_tdata/m_tlast hold until accepted.
  - m_tvalid never depends combinationally on m_tready.
- FSM:
  - IDLE:
    - length_tready=1, s_tready=0, m_tvalid=0.
    - On length handshake: latch plen=length_tdata, ulen=plen+8 (16-bit, modulo 2^16), hcnt=0, go HDR.
  - HDR:
    - m_tvalid=1; m_tdata=header byte[hcnt], big-endian: SRC[15:8], SRC[7:0], DST[15:8], DST[7:0], ulen[15:8], ulen[7:0], 8'h00, 8'h00.
    - Advance hcnt on m handshake.
    - After byte 7 accepted: go PAYLOAD if plen!=0, else IDLE. If plen==0, byte 7 carries m_tlast=1.
    - s_tready=0 and length_tready=0 throughout.
  - PAYLOAD:
    - Zero-latency pass-through: m_tvalid=s_tvalid, m_tdata=s_tdata, m_tlast=s_tlast, s_tready=m_tready.
    - pcnt increments on each handshake.
    - On handshake with s_tlast=1: go IDLE.
- Framing is authoritative from s_tlast, never from plen.
- len_err:
  - Registered.
  - Pulses the cycle after the s_tlast handshake when pcnt+1 != plen.
  - Also pulses on leaving HDR if plen+8 overflowed 16 bits (plen > 65527).
- Throughput:
  - Back-to-back datagrams: one idle cycle (IDLE) between last payload byte and the next header's first byte.
  - Header plus payload otherwise streams at one byte per cycle when m_tready=1.
- pcnt is 16 bits and wraps silently. A wrap still yields len_err at end-of-packet if the count mismatches.

Decomposition:
- Package udp_pkg:
  - UDP_HDR_LEN=8.
  - state typedef enum {IDLE, HDR, PAYLOAD}.
  - typedef for 16-bit length.
  - Function udp_hdr_byte(idx, src, dst, ulen) returning header byte.
- No sub-module: header mux is the package function. FSM and counters live in one module.

Test Plan:
- Length 1020, payload bytes 0x01..0xFC repeating, m_tready=1 -> output begins 12 34 56 78 04 04 00 00; then 1020 payload bytes identical and in order; m_tlast only on byte 1028; len_err=0.
- Same packet, m_tready toggling 1-of-3 cycles -> identical byte sequence; m_tdata stable while m_tvalid&&!m_tready; no byte lost or duplicated.
- Two back-to-back packets of lengths 1 and 2 -> headers carry ulen 0x0009 then 0x000A; exactly one IDLE cycle between the first m_tlast and the second header byte 0.
- Length 0 -> 8 header bytes with ulen 0x0008; m_tlast on byte 7; s_tready stays 0; returns to IDLE.
- Length 5 with s_tlast on the 4th byte -> 12 output bytes, m_tlast on the 4th payload byte, len_err pulses 1 cycle. Length 65530 -> ulen 0x0002 and len_err pulses after header.
- reset asserted during HDR byte 3 -> next cycle m_tvalid=0, length_tready=1 (IDLE); next length word produces a fresh header starting at byte 0.

Source files
------------

// File: rtl/udp_pkg.sv
// Shared types, constants and the UDP header byte mux for the UDP header insert stage.
package udp_pkg;

    localparam int UDP_HDR_LEN = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2
    } udp_state_t;

    typedef logic [15:0] udp_len_t;

    // Header byte idx of a UDP header, big-endian fields, checksum fixed at zero.
    function automatic logic [7:0] udp_hdr_byte(
        input logic [2:0] idx,
        input logic [15:0] src,
        input logic [15:0] dst,
        input udp_len_t    ulen
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = src[15:8];
            3'd1:    b = src[7:0];
            3'd2:    b = dst[15:8];
            3'd3:    b = dst[7:0];
            3'd4:    b = ulen[15:8];
            3'd5:    b = ulen[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/udp_hdr_insert.sv
// UDP header insert: takes a payload length word and the payload byte stream,
// emits an 8-byte UDP header followed by the payload passed straight through.
//
// Handshake semantics (all three streams): a byte/word moves on a cycle where
// valid && ready are both high at the rising clock edge. A producer holds valid
// and its data stable until the transfer happens. m_tvalid never looks at
// m_tready; in PAYLOAD it is a straight copy of s_tvalid.
module udp_hdr_insert
    import udp_pkg::*;
#(
    parameter logic [15:0] SRC_PORT = 16'h1234,
    parameter logic [15:0] DST_PORT = 16'h5678
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        length_tvalid,
    output logic        length_tready,
    input  logic [15:0] length_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic [7:0]  s_tdata,
    input  logic        s_tlast,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [7:0]  m_tdata,
    output logic        m_tlast,
    output logic        len_err,
    output logic [1:0]  dbg_state
);

    udp_state_t state_q, state_d;
    logic [2:0] hcnt_q, hcnt_d;
    udp_len_t   pcnt_q, pcnt_d;
    udp_len_t   plen_q;
    udp_len_t   ulen_q;
    logic       ovf_q;
    logic       len_err_q, len_err_d;
    logic       len_load;

    assign len_err   = len_err_q;
    assign dbg_state = state_q;

    // Next-state, counters and stream outputs; everything is forced quiet while reset is high.
    always_comb begin
        state_d       = state_q;
        hcnt_d        = hcnt_q;
        pcnt_d        = pcnt_q;
        len_err_d     = 1'b0;
        len_load      = 1'b0;
        length_tready = 1'b0;
        s_tready      = 1'b0;
        m_tvalid      = 1'b0;
        m_tdata       = 8'h00;
        m_tlast       = 1'b0;

        case (state_q)
            IDLE: begin
                length_tready = 1'b1;
                if (length_tvalid) begin
                    len_load = 1'b1;
                    hcnt_d   = 3'd0;
                    pcnt_d   = '0;
                    state_d  = HDR;
                end
            end

            HDR: begin
                m_tvalid = 1'b1;
                m_tdata  = udp_hdr_byte(hcnt_q, SRC_PORT, DST_PORT, ulen_q);
                // An empty datagram ends on the last checksum byte.
                m_tlast  = (hcnt_q == 3'(UDP_HDR_LEN - 1)) && (plen_q == '0);
                if (m_tready) begin
                    if (hcnt_q == 3'(UDP_HDR_LEN - 1)) begin
                        state_d   = (plen_q != '0) ? PAYLOAD : IDLE;
                        len_err_d = ovf_q;
                    end else begin
                        hcnt_d = hcnt_q + 3'd1;
                    end
                end
            end

            PAYLOAD: begin
                m_tvalid = s_tvalid;
                m_tdata  = s_tdata;
                m_tlast  = s_tlast;
                s_tready = m_tready;
                if (s_tvalid && m_tready) begin
                    pcnt_d = pcnt_q + 16'd1;
                    // s_tlast alone frames the packet; the length only feeds the error flag.
                    if (s_tlast) begin
                        state_d   = IDLE;
                        len_err_d = ((pcnt_q + 16'd1) != plen_q);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (reset) begin
            length_tready = 1'b0;
            s_tready      = 1'b0;
            m_tvalid      = 1'b0;
            m_tdata       = 8'h00;
            m_tlast       = 1'b0;
            len_load      = 1'b0;
        end
    end

    // State, counters, captured lengths and the registered error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            hcnt_q    <= 3'd0;
            pcnt_q    <= '0;
            plen_q    <= '0;
            ulen_q    <= '0;
            ovf_q     <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            pcnt_q    <= pcnt_d;
            len_err_q <= len_err_d;
            if (len_load) begin
                plen_q <= length_tdata;
                ulen_q <= length_tdata + 16'd8;
                ovf_q  <= (length_tdata > 16'd65527);
            end
        end
    end

endmodule

// File: tb/tb_udp_hdr_insert.sv
// Directed bench for udp_hdr_insert: header bytes, payload pass-through,
// backpressure, back-to-back gap, empty datagram, length errors, mid-header reset.
module tb_udp_hdr_insert;

    logic        clk;
    logic        reset;
    logic        length_tvalid;
    logic        length_tready;
    logic [15:0] length_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [7:0]  s_tdata;
    logic        s_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic [7:0]  m_tdata;
    logic        m_tlast;
    logic        len_err;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;
    int cyc_g = 0;

    // {tlast, data} of every byte the DUT should emit, in order.
    logic [8:0] exp_q[$];

    udp_hdr_insert #(
        .SRC_PORT(16'h1234),
        .DST_PORT(16'h5678)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .length_tvalid(length_tvalid),
        .length_tready(length_tready),
        .length_tdata (length_tdata),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .s_tdata      (s_tdata),
        .s_tlast      (s_tlast),
        .m_tvalid     (m_tvalid),
        .m_tready     (m_tready),
        .m_tdata      (m_tdata),
        .m_tlast      (m_tlast),
        .len_err      (len_err),
        .dbg_state    (dbg_state)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc_g <= cyc_g + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pay(input int i);
        return 8'((i % 252) + 1);
    endfunction

    task automatic push_header(input logic [15:0] plen, input bit empty);
        logic [15:0] ulen;
        ulen = plen + 16'd8;
        exp_q.push_back({1'b0, 8'h12});
        exp_q.push_back({1'b0, 8'h34});
        exp_q.push_back({1'b0, 8'h56});
        exp_q.push_back({1'b0, 8'h78});
        exp_q.push_back({1'b0, ulen[15:8]});
        exp_q.push_back({1'b0, ulen[7:0]});
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({empty, 8'h00});
    endtask

    // Entered at a falling edge with the DUT in IDLE. Sends one length word and
    // nbytes payload bytes; rmode 1 gives m_tready high one cycle in three.
    task automatic run_packet(input logic [15:0] plen, input int nbytes, input int rmode,
                              output int errs, output int first_cyc, output int last_cyc,
                              output int s_rdy_seen);
        int sent;
        int cyc;
        int limit;
        bit done;
        bit held;
        logic [8:0] held_v;
        logic [8:0] e;
        errs = 0; first_cyc = -1; last_cyc = -1; s_rdy_seen = 0;
        push_header(plen, nbytes == 0);
        for (int i = 0; i < nbytes; i++) exp_q.push_back({i == nbytes - 1, pay(i)});

        length_tvalid = 1'b1;
        length_tdata  = plen;
        #1;
        check("length_tready_idle", length_tready, 1);
        @(negedge clk);
        length_tvalid = 1'b0;

        sent = 0; cyc = 0; done = 0; held = 0; held_v = '0;
        limit = 8 * nbytes + 100;
        while (!done && cyc < limit) begin
            m_tready = (rmode == 0) ? 1'b1 : (cyc % 3 == 0);
            s_tvalid = (sent < nbytes);
            s_tdata  = pay(sent);
            s_tlast  = (sent == nbytes - 1);
            #1;
            if (len_err) errs++;
            if (s_tready) s_rdy_seen++;
            if (held) begin
                check("hold_valid", m_tvalid, 1);
                check("hold_data", {m_tlast, m_tdata}, held_v);
            end
            held = 0;
            if (m_tvalid && first_cyc < 0) first_cyc = cyc_g;
            if (m_tvalid && !m_tready) begin
                held = 1;
                held_v = {m_tlast, m_tdata};
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_byte", {m_tlast, m_tdata}, 9'h1ff);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", {m_tlast, m_tdata}, e);
                end
                if (m_tlast) begin
                    done = 1;
                    last_cyc = cyc_g;
                end
            end
            if (s_tvalid && s_tready) sent++;
            @(negedge clk);
            cyc++;
        end
        check("packet_done_in_budget", done, 1);
        check("exp_q_drained", exp_q.size(), 0);
        exp_q.delete();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        #1;
        if (len_err) errs++;
        check("back_to_idle", dbg_state, 0);
        check("idle_m_tvalid", m_tvalid, 0);
    endtask

    initial begin
        int errs, fc, lc, sr, lc1;
        reset = 1'b1; length_tvalid = 1'b0; length_tdata = '0;
        s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0;

        // Reset behaviour.
        repeat (2) @(negedge clk);
        #1;
        check("rst_length_tready", length_tready, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_len_err", len_err, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_length_tready", length_tready, 1);
        check("post_rst_state", dbg_state, 0);
        @(negedge clk);

        // 1020-byte packet, full throughput: header 12 34 56 78 04 04 00 00.
        run_packet(16'd1020, 1020, 0, errs, fc, lc, sr);
        check("p1020_len_err", errs, 0);
        check("p1020_cycles", lc - fc, 1027);

        // Same packet under backpressure.
        run_packet(16'd1020, 1020, 1, errs, fc, lc, sr);
        check("p1020_bp_len_err", errs, 0);

        // Back-to-back 1 and 2 byte packets: one IDLE cycle between them.
        run_packet(16'd1, 1, 0, errs, fc, lc1, sr);
        check("p1_len_err", errs, 0);
        run_packet(16'd2, 2, 0, errs, fc, lc, sr);
        check("p2_len_err", errs, 0);
        check("b2b_gap", fc - lc1, 2);

        // Empty datagram.
        run_packet(16'd0, 0, 0, errs, fc, lc, sr);
        check("p0_len_err", errs, 0);
        check("p0_s_tready_never", sr, 0);
        check("p0_cycles", lc - fc, 7);

        // Short packet: length 5, tlast on 4th byte.
        run_packet(16'd5, 4, 0, errs, fc, lc, sr);
        check("short_len_err_pulses", errs, 1);

        // Length overflow: ulen wraps to 0x0002, plus mismatch at end.
        run_packet(16'd65530, 3, 0, errs, fc, lc, sr);
        check("ovf_len_err_pulses", errs, 2);

        // Reset during header byte 3.
        length_tvalid = 1'b1; length_tdata = 16'd10;
        #1;
        check("rst_test_length_tready", length_tready, 1);
        @(negedge clk);
        length_tvalid = 1'b0; m_tready = 1'b1;
        #1; check("rst_test_b0", m_tdata, 8'h12);
        @(negedge clk);
        #1; check("rst_test_b1", m_tdata, 8'h34);
        @(negedge clk);
        #1; check("rst_test_b2", m_tdata, 8'h56);
        @(negedge clk);
        #1; check("rst_test_b3", m_tdata, 8'h78);
        reset = 1'b1;
        #1; check("rst_mid_m_tvalid", m_tvalid, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("after_rst_m_tvalid", m_tvalid, 0);
        check("after_rst_length_tready", length_tready, 1);
        check("after_rst_state", dbg_state, 0);
        @(negedge clk);
        run_packet(16'd2, 2, 0, errs, fc, lc, sr);
        check("after_rst_pkt_len_err", errs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
